// File: rtl/game_flow_controller.sv
// game_flow_controller: Pong match sequencer (idle/serve/play/pause/point/over), owns scores; ports: CLOCK_25, reset, frame_tick, start_btn, pause_btn, point_p1/2 in; game_run, ball_reset, serve_dir, score_1/2, winner, state out
module game_flow_controller #(
  parameter int SCORE_W      = 3,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int HOLD_FRAMES  = 90,
  parameter int CNT_W        = 8
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic               game_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    POINT  = 3'd4,
    OVER   = 3'd5
  } state_t;
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] S_ONE   = SCORE_W'(1);
  localparam logic [CNT_W-1:0]   C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   SERVE_N = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   HOLD_N  = CNT_W'(HOLD_FRAMES);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0]         win_q, win_d;
  logic               dir_q, dir_d, run_q, run_d, br_q, br_d;
  logic [2:0]         start_sync_q, pause_sync_q;
  logic               start_ev, pause_ev;
  // [0],[1] synchronise; [2] holds the previous synchronised level for edge detection
  assign start_ev = start_sync_q[1] & ~start_sync_q[2];
  assign pause_ev = pause_sync_q[1] & ~pause_sync_q[2];
  assign cnt_inc  = cnt_q + C_ONE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE, OVER: if (start_ev) begin
        s1_d    = '0;
        s2_d    = '0;
        win_d   = 2'b00;
        state_d = SERVE;
      end
      SERVE: if (frame_tick) begin
        cnt_d   = cnt_inc;
        state_d = cnt_inc == SERVE_N ? PLAY : SERVE;
      end
      PLAY: begin
        // a point outranks a simultaneous pause; a double point scores nobody
        if (point_p1 && point_p2) state_d = POINT;
        else if (point_p1) begin
          s1_d    = s1_q == WIN ? s1_q : s1_q + S_ONE;
          dir_d   = 1'b0;
          state_d = POINT;
        end else if (point_p2) begin
          s2_d    = s2_q == WIN ? s2_q : s2_q + S_ONE;
          dir_d   = 1'b1;
          state_d = POINT;
        end else if (pause_ev) state_d = PAUSED;
      end
      PAUSED: state_d = pause_ev ? PLAY : start_ev ? IDLE : PAUSED;
      POINT: if (frame_tick) begin
        cnt_d = cnt_inc;
        if (cnt_inc == HOLD_N) begin
          win_d   = s1_q == WIN ? 2'b01 : s2_q == WIN ? 2'b10 : 2'b00;
          state_d = (s1_q == WIN || s2_q == WIN) ? OVER : SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    run_d = state_d == PLAY;
    br_d  = state_d == SERVE && state_q != SERVE;
  end
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      win_q        <= 2'b00;
      dir_q        <= 1'b0;
      run_q        <= 1'b0;
      br_q         <= 1'b0;
      start_sync_q <= '0;
      pause_sync_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      win_q        <= win_d;
      dir_q        <= dir_d;
      run_q        <= run_d;
      br_q         <= br_d;
      start_sync_q <= {start_sync_q[1:0], start_btn};
      pause_sync_q <= {pause_sync_q[1:0], pause_btn};
    end
  end
  assign game_run   = run_q;
  assign ball_reset = br_q;
  assign serve_dir  = dir_q;
  assign score_1    = s1_q;
  assign score_2    = s2_q;
  assign winner     = win_q;
  assign state      = state_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: scoreboard-driven bench for game_flow_controller
module tb_game_flow_controller;
  typedef struct packed {
    logic [2:0] st;
    logic       gr;
    logic       br;
    logic       dir;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [1:0] win;
  } obs_t;
  logic clk = 0, rst = 1;
  logic frame_tick = 0, start_btn = 0, pause_btn = 0, point_p1 = 0, point_p2 = 0;
  logic game_run, ball_reset, serve_dir;
  logic [2:0] score_1, score_2, state;
  logic [1:0] winner;
  int errors = 0, checks = 0;
  logic [2:0] exp_s1 = 0, exp_s2 = 0;
  logic [1:0] exp_win = 0;
  logic exp_dir = 0;
  obs_t exp_q[$];
  obs_t got, want;
  game_flow_controller dut (
    .CLOCK_25(clk), .reset(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .point_p1(point_p1), .point_p2(point_p2), .game_run(game_run),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .score_1(score_1), .score_2(score_2),
    .winner(winner), .state(state)
  );
  always #20 clk = ~clk;
  function automatic obs_t mk(input logic [2:0] st, input logic gr, input logic br);
    return '{st, gr, br, exp_dir, exp_s1, exp_s2, exp_win};
  endfunction
  function automatic obs_t snap();
    return '{state, game_run, ball_reset, serve_dir, score_1, score_2, winner};
  endfunction
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1;
      @(negedge clk);
      frame_tick = 0;
      @(negedge clk);
    end
  endtask
  task automatic press(input bit is_pause);
    if (is_pause) pause_btn = 1; else start_btn = 1;
    repeat (3) @(negedge clk);
  endtask
  task automatic release_btns();
    start_btn = 0;
    pause_btn = 0;
    repeat (4) @(negedge clk);
  endtask
  task automatic pulse_point(input logic p1, input logic p2);
    point_p1 = p1;
    point_p2 = p2;
    @(negedge clk);
    point_p1 = 0;
    point_p2 = 0;
  endtask
  task automatic test_reset();
    exp_q.push_back(mk(3'd0, 0, 0));
    repeat (3) @(negedge clk);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset got=%h want=%h", got, want); end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_start_serve();
    exp_q.push_back(mk(3'd1, 0, 1));
    exp_q.push_back(mk(3'd1, 0, 0));
    exp_q.push_back(mk(3'd1, 0, 0));
    exp_q.push_back(mk(3'd2, 1, 0));
    press(0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL start_enter got=%h want=%h", got, want); end
    @(negedge clk);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL start_br_drop got=%h want=%h", got, want); end
    release_btns();
    ticks(59);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL serve_59 got=%h want=%h", got, want); end
    ticks(1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL serve_60 got=%h want=%h", got, want); end
  endtask
  task automatic test_point();
    exp_s2 = 1; exp_dir = 1;
    exp_q.push_back(mk(3'd4, 0, 0));
    exp_q.push_back(mk(3'd4, 0, 0));
    exp_q.push_back(mk(3'd1, 0, 1));
    exp_q.push_back(mk(3'd2, 1, 0));
    pulse_point(0, 1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL point_p2 got=%h want=%h", got, want); end
    ticks(89);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL hold_89 got=%h want=%h", got, want); end
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL hold_90 got=%h want=%h", got, want); end
    @(negedge clk);
    ticks(60);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reserve got=%h want=%h", got, want); end
  endtask
  task automatic test_double_point();
    exp_q.push_back(mk(3'd4, 0, 0));
    exp_q.push_back(mk(3'd2, 1, 0));
    pulse_point(1, 1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL double_point got=%h want=%h", got, want); end
    ticks(90);
    ticks(60);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL double_resume got=%h want=%h", got, want); end
  endtask
  task automatic test_pause();
    exp_q.push_back(mk(3'd3, 0, 0));
    exp_q.push_back(mk(3'd3, 0, 0));
    exp_q.push_back(mk(3'd2, 1, 0));
    press(1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL pause_enter got=%h want=%h", got, want); end
    release_btns();
    pulse_point(1, 0);
    ticks(100);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL pause_frozen got=%h want=%h", got, want); end
    press(1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL pause_resume got=%h want=%h", got, want); end
    release_btns();
  endtask
  task automatic test_pause_vs_point();
    exp_s1 = exp_s1 + 1; exp_dir = 0;
    exp_q.push_back(mk(3'd4, 0, 0));
    exp_q.push_back(mk(3'd2, 1, 0));
    pause_btn = 1;
    repeat (2) @(negedge clk);
    pulse_point(1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL point_beats_pause got=%h want=%h", got, want); end
    release_btns();
    ticks(90);
    ticks(60);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL post_pause_point got=%h want=%h", got, want); end
  endtask
  task automatic test_win();
    while (exp_s1 < 4) begin
      exp_s1 = exp_s1 + 1; exp_dir = 0;
      exp_q.push_back(mk(3'd4, 0, 0));
      pulse_point(1, 0);
      got = snap(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL score_step got=%h want=%h", got, want); end
      ticks(90);
      ticks(60);
    end
    exp_s1 = 5;
    exp_q.push_back(mk(3'd4, 0, 0));
    pulse_point(1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL score_5 got=%h want=%h", got, want); end
    exp_win = 2'b01;
    exp_q.push_back(mk(3'd5, 0, 0));
    exp_q.push_back(mk(3'd5, 0, 0));
    ticks(90);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL game_over got=%h want=%h", got, want); end
    pulse_point(1, 0);
    ticks(3);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL over_ignores_point got=%h want=%h", got, want); end
    exp_s1 = 0; exp_s2 = 0; exp_win = 0;
    exp_q.push_back(mk(3'd1, 0, 1));
    press(0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL restart got=%h want=%h", got, want); end
    release_btns();
  endtask
  task automatic test_reset_mid_serve();
    int br_cnt;
    exp_dir = 0;
    exp_q.push_back(mk(3'd0, 0, 0));
    exp_q.push_back(mk(3'd1, 0, 0));
    ticks(30);
    #5 rst = 1;
    #1;
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL async_reset got=%h want=%h", got, want); end
    start_btn = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    br_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ball_reset === 1'b1) br_cnt++;
    end
    start_btn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ball_reset === 1'b1) br_cnt++;
    end
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL held_start_state got=%h want=%h", got, want); end
    checks++;
    if (br_cnt !== 1) begin errors++; $display("FAIL held_start_events got=%0d want=1", br_cnt); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_start_serve();
    test_point();
    test_double_point();
    test_pause();
    test_pause_vs_point();
    test_win();
    test_reset_mid_serve();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
